// File: rtl/traffic_sense_timer.sv
// Input conditioning and interval timing ahead of the traffic next-state controller:
// synchronizes/debounces the car sensor and runs a prescaled, clearable interval timer.
module traffic_sense_timer #(
    parameter int PRESCALE      = 4,
    parameter int TICK_W        = 8,
    parameter int YELLOW_TICKS  = 3,
    parameter int COUNTRY_TICKS = 10,
    parameter int DEBOUNCE      = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              t_reset,
    input  logic              car_raw,
    output logic              car_sync,
    output logic              time_yellow,
    output logic              time_country,
    output logic              tick,
    output logic [TICK_W-1:0] elapsed
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [PW-1:0]     PRESC_LAST    = PW'(PRESCALE - 1);
    localparam logic [DW-1:0]     DEB_LAST      = DW'(DEBOUNCE - 1);
    localparam logic [TICK_W-1:0] YELLOW_LIMIT  = TICK_W'(YELLOW_TICKS);
    localparam logic [TICK_W-1:0] COUNTRY_LIMIT = TICK_W'(COUNTRY_TICKS);

    logic [PW-1:0]     presc;
    logic              wrap;
    logic [TICK_W-1:0] elapsed_next;

    assign wrap = (presc == PRESC_LAST);

    // Flags are derived from the value elapsed is about to take so they rise on the same edge.
    always_comb begin
        elapsed_next = elapsed;
        if (wrap && (elapsed != {TICK_W{1'b1}})) begin
            elapsed_next = elapsed + TICK_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc        <= '0;
            tick         <= 1'b0;
            elapsed      <= '0;
            time_yellow  <= 1'b0;
            time_country <= 1'b0;
        end else if (t_reset) begin
            presc        <= '0;
            tick         <= 1'b0;
            elapsed      <= '0;
            time_yellow  <= 1'b0;
            time_country <= 1'b0;
        end else begin
            presc        <= wrap ? '0 : presc + PW'(1);
            tick         <= wrap;
            elapsed      <= elapsed_next;
            time_yellow  <= (elapsed_next >= YELLOW_LIMIT);
            time_country <= (elapsed_next >= COUNTRY_LIMIT);
        end
    end

    logic          car_s1;
    logic          car_s2;
    logic [DW-1:0] deb_cnt;

    // Car path ignores t_reset; only the global reset touches it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            car_s1   <= 1'b0;
            car_s2   <= 1'b0;
            deb_cnt  <= '0;
            car_sync <= 1'b0;
        end else begin
            car_s1 <= car_raw;
            car_s2 <= car_s1;
            if (car_s2 == car_sync) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt  <= '0;
                car_sync <= car_s2;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_traffic_sense_timer.sv
// Directed bench for traffic_sense_timer: table-driven timer vectors plus
// hand-written sequences for reset, clear, and debounce corner cases.
module tb_traffic_sense_timer;

    logic       clock;
    logic       reset;
    logic       t_reset;
    logic       car_raw;
    logic       car_sync;
    logic       time_yellow;
    logic       time_country;
    logic       tick;
    logic [7:0] elapsed;

    int checks = 0;
    int errors = 0;

    traffic_sense_timer dut (
        .clock        (clock),
        .reset        (reset),
        .t_reset      (t_reset),
        .car_raw      (car_raw),
        .car_sync     (car_sync),
        .time_yellow  (time_yellow),
        .time_country (time_country),
        .tick         (tick),
        .elapsed      (elapsed)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int         edge_n;
        logic [7:0] el;
        logic       tk;
        logic       y;
        logic       c;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [0:NV-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " elapsed"}, 32'(elapsed), 0);
        chk({tag, " tick"}, 32'(tick), 0);
        chk({tag, " yellow"}, 32'(time_yellow), 0);
        chk({tag, " country"}, 32'(time_country), 0);
        chk({tag, " car_sync"}, 32'(car_sync), 0);
    endtask

    // Caller must be between edge 0 and edge 1 of the timer origin.
    task automatic run_vecs(input int lo, input int hi, input string tag);
        int cur = 0;
        for (int i = lo; i <= hi; i++) begin
            repeat (vecs[i].edge_n - cur) @(posedge clock);
            cur = vecs[i].edge_n;
            #1;
            chk($sformatf("%s e%0d elapsed", tag, cur), 32'(elapsed), 32'(vecs[i].el));
            chk($sformatf("%s e%0d tick", tag, cur), 32'(tick), 32'(vecs[i].tk));
            chk($sformatf("%s e%0d yellow", tag, cur), 32'(time_yellow), 32'(vecs[i].y));
            chk($sformatf("%s e%0d country", tag, cur), 32'(time_country), 32'(vecs[i].c));
        end
    endtask

    task automatic pulse_t_reset();
        @(negedge clock) t_reset = 1'b1;
        @(posedge clock);
        @(negedge clock) t_reset = 1'b0;
    endtask

    initial begin
        // Section A: timing from a clear / reset release.
        vecs[0]  = '{1,   8'd0,   1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3,   8'd0,   1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4,   8'd1,   1'b1, 1'b0, 1'b0};
        vecs[3]  = '{5,   8'd1,   1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8,   8'd2,   1'b1, 1'b0, 1'b0};
        vecs[5]  = '{11,  8'd2,   1'b0, 1'b0, 1'b0};
        vecs[6]  = '{12,  8'd3,   1'b1, 1'b1, 1'b0};
        vecs[7]  = '{13,  8'd3,   1'b0, 1'b1, 1'b0};
        vecs[8]  = '{39,  8'd9,   1'b0, 1'b1, 1'b0};
        vecs[9]  = '{40,  8'd10,  1'b1, 1'b1, 1'b1};
        vecs[10] = '{41,  8'd10,  1'b0, 1'b1, 1'b1};
        vecs[11] = '{44,  8'd11,  1'b1, 1'b1, 1'b1};
        // Section B: saturation.
        vecs[12] = '{1019, 8'd254, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1020, 8'd255, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1021, 8'd255, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1023, 8'd255, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1024, 8'd255, 1'b1, 1'b1, 1'b1};
        vecs[17] = '{1100, 8'd255, 1'b1, 1'b1, 1'b1};
        // Section C: recount after a mid-count clear.
        vecs[18] = '{11,  8'd2,   1'b0, 1'b0, 1'b0};
        vecs[19] = '{12,  8'd3,   1'b1, 1'b1, 1'b0};

        reset   = 1'b0;
        t_reset = 1'b0;
        car_raw = 1'b0;

        // Power-up: async reset between edges.
        #2 reset = 1'b1;
        #1 chk_all_zero("powerup async");
        repeat (3) @(posedge clock);
        #1 chk_all_zero("powerup held");
        @(negedge clock) reset = 1'b0;
        run_vecs(0, 11, "powerup");

        // Glitch of three cycles must not reach car_sync.
        @(negedge clock) car_raw = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock) car_raw = 1'b0;
        for (int i = 3; i <= 10; i++) begin
            @(posedge clock);
            #1 chk($sformatf("glitch k+%0d car_sync", i), 32'(car_sync), 0);
        end

        // Held rise: car_sync at edge k+5.
        @(negedge clock) car_raw = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(posedge clock);
            #1 chk($sformatf("rise k+%0d car_sync", i), 32'(car_sync), (i == 5) ? 1 : 0);
        end

        // Threshold timing after a one-edge clear, then async reset mid-operation.
        pulse_t_reset();
        run_vecs(0, 11, "clear");
        chk("premid car_sync", 32'(car_sync), 1);
        #2 reset = 1'b1;
        #1 chk_all_zero("midop async");
        repeat (2) @(posedge clock);
        #1 chk_all_zero("midop held");
        @(negedge clock) reset = 1'b0;
        run_vecs(0, 11, "after midop");

        // Mid-count clear coinciding with a prescaler wrap.
        pulse_t_reset();
        repeat (20) @(posedge clock);
        #1;
        chk("midclr e20 elapsed", 32'(elapsed), 5);
        chk("midclr e20 tick", 32'(tick), 1);
        chk("midclr e20 yellow", 32'(time_yellow), 1);
        repeat (3) @(posedge clock);
        #1;
        chk("midclr e23 elapsed", 32'(elapsed), 5);
        chk("midclr e23 tick", 32'(tick), 0);
        @(negedge clock) t_reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midclr e24 elapsed", 32'(elapsed), 0);
        chk("midclr e24 tick", 32'(tick), 0);
        chk("midclr e24 yellow", 32'(time_yellow), 0);
        chk("midclr e24 country", 32'(time_country), 0);
        @(negedge clock) t_reset = 1'b0;
        run_vecs(18, 19, "midclr recount");

        // Saturation.
        pulse_t_reset();
        run_vecs(12, 17, "sat");

        // Car release: car_sync falls five edges later.
        chk("prefall car_sync", 32'(car_sync), 1);
        @(negedge clock) car_raw = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            @(posedge clock);
            #1 chk($sformatf("fall k+%0d car_sync", i), 32'(car_sync), (i < 5) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
